sub_bytes_seq: RTL and testbench

//  Sequential, lane-parametrised AES SubBytes engine. Replaces the fully parallel 16-sbox array with

---
 rtl/sub_bytes_seq.sv | 141 ++++++++++++++
 tb/tb_sub_bytes_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes engine: LANES byte-substitution units time-shared
// over 16/LANES cycles, with valid/ready handshakes on input and output and
// an optional per-block inverse mode.
module sub_bytes_seq #(
    parameter int LANES  = 4,
    parameter int INV_EN = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_inv,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    localparam int N  = 16 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    // Forward S-box, byte 0x00 in the most significant position.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] tbl_lookup(input logic [2047:0] tbl, input logic [7:0] idx);
        return tbl[{8'd255 - idx, 3'b000} +: 8];
    endfunction

    // Inverse table is derived from the forward table at elaboration time.
    function automatic logic [2047:0] build_inv();
        logic [2047:0] t;
        logic [7:0]    s;
        t = '0;
        for (int unsigned i = 0; i < 256; i++) begin
            s = tbl_lookup(SBOX_TBL, 8'(i));
            t[{8'd255 - s, 3'b000} +: 8] = 8'(i);
        end
        return t;
    endfunction

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q;
    logic [127:0]        buf_q, buf_next;
    logic                mode_q;
    logic                accept, last;
    logic [8*LANES-1:0]  lane_res;

    assign last   = (cnt_q == CW'(N - 1));
    assign accept = in_valid & in_ready;

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [7:0] b_in, b_fwd;
        assign b_in  = buf_q[8*(LANES*32'(cnt_q) + j) +: 8];
        assign b_fwd = tbl_lookup(SBOX_TBL, b_in);
        if (INV_EN != 0) begin : g_inv
            localparam logic [2047:0] INV_TBL = build_inv();
            assign lane_res[8*j +: 8] = mode_q ? tbl_lookup(INV_TBL, b_in) : b_fwd;
        end else begin : g_fwd
            assign lane_res[8*j +: 8] = b_fwd;
        end
    end

    if (INV_EN == 0) begin : g_no_inv
        logic unused_mode;
        assign unused_mode = mode_q;
    end

    // Write the lane results back into the bytes selected by cnt.
    always_comb begin
        buf_next = buf_q;
        for (int unsigned j = 0; j < LANES; j++) begin
            buf_next[8*(LANES*32'(cnt_q) + j) +: 8] = lane_res[8*j +: 8];
        end
    end

    // Next-state and handshake outputs; in_ready is combinational from out_ready in DONE.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    in_ready = 1'b1;
                    state_d  = in_valid ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, byte buffer, lane counter and registered output block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            buf_q     <= '0;
            mode_q    <= 1'b0;
            state_out <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                buf_q  <= state_in;
                mode_q <= in_inv & (INV_EN != 0);
                cnt_q  <= '0;
            end else if (state_q == RUN) begin
                buf_q <= buf_next;
                cnt_q <= last ? '0 : cnt_q + 1'b1;
                if (last) state_out <= buf_next;
            end
        end
    end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Self-checking bench for sub_bytes_seq: fixed vectors, handshake corner
// cases, randomized blocks and lane-count variants against a GF(2^8) model.
module tb_sub_bytes_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_inv;
    logic         out_ready;
    logic [127:0] state_in;

    logic         ir [5];
    logic         ov [5];
    logic         bz [5];
    logic [127:0] so [5];

    localparam int LAT [5] = '{16, 8, 4, 2, 1};
    localparam int IEN [5] = '{0, 0, 1, 1, 0};
    localparam int M = 2;  // main instance: LANES=4, INV_EN=1

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] ref_fwd [256];
    logic [7:0] ref_inv [256];

    always #5 clk = ~clk;

    sub_bytes_seq #(.LANES(1), .INV_EN(0)) u_l1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_inv(in_inv),
        .state_in(state_in), .out_valid(ov[0]), .out_ready(out_ready), .state_out(so[0]), .busy(bz[0]));
    sub_bytes_seq #(.LANES(2), .INV_EN(0)) u_l2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_inv(in_inv),
        .state_in(state_in), .out_valid(ov[1]), .out_ready(out_ready), .state_out(so[1]), .busy(bz[1]));
    sub_bytes_seq #(.LANES(4), .INV_EN(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_inv(in_inv),
        .state_in(state_in), .out_valid(ov[2]), .out_ready(out_ready), .state_out(so[2]), .busy(bz[2]));
    sub_bytes_seq #(.LANES(8), .INV_EN(1)) u_l8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .in_inv(in_inv),
        .state_in(state_in), .out_valid(ov[3]), .out_ready(out_ready), .state_out(so[3]), .busy(bz[3]));
    sub_bytes_seq #(.LANES(16), .INV_EN(0)) u_l16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[4]), .in_inv(in_inv),
        .state_in(state_in), .out_valid(ov[4]), .out_ready(out_ready), .state_out(so[4]), .busy(bz[4]));

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_ref();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                inv = 8'h01;
                for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
            end
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            ref_fwd[x] = s;
        end
        for (int x = 0; x < 256; x++) ref_inv[ref_fwd[x]] = 8'(x);
    endtask

    function automatic logic [127:0] model(input logic [127:0] d, input logic inv, input int inv_en);
        logic [127:0] r;
        for (int k = 0; k < 16; k++)
            r[8*k +: 8] = (inv && inv_en != 0) ? ref_inv[d[8*k +: 8]] : ref_fwd[d[8*k +: 8]];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_ov(output int lat);
        lat = 99;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (ov[M]) begin
                lat = c;
                break;
            end
        end
    endtask

    // One block through the main instance, optionally stalling the consumer.
    task automatic run_block(input string nm, input logic [127:0] d, input logic inv,
                             input logic [127:0] exp, input int stall);
        int           lat;
        logic [127:0] held;
        @(negedge clk);
        chk({nm, "_in_ready"}, 128'(ir[M]), 128'd1);
        state_in = d; in_inv = inv; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({nm, "_busy"}, 128'(bz[M]), 128'd1);
        wait_ov(lat);
        chk({nm, "_latency"}, 128'(lat), 128'd4);
        chk({nm, "_data"}, so[M], exp);
        held = so[M];
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk({nm, "_stall_data"}, so[M], held);
            chk({nm, "_stall_valid"}, 128'(ov[M]), 128'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, "_released"}, 128'(ov[M]), 128'd0);
    endtask

    // Same block into every lane variant; each reports its own latency and result.
    task automatic multi_block(input string nm, input logic [127:0] d, input logic inv);
        int           lat [5];
        logic [127:0] got [5];
        for (int i = 0; i < 5; i++) begin lat[i] = 99; got[i] = '0; end
        @(negedge clk);
        state_in = d; in_inv = inv; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 5; i++)
                if (ov[i] && lat[i] == 99) begin lat[i] = c; got[i] = so[i]; end
        end
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("%s_lat_L%0d", nm, 16 / LAT[i]), 128'(lat[i]), 128'(LAT[i]));
            chk($sformatf("%s_data_L%0d", nm, 16 / LAT[i]), got[i], model(d, inv, IEN[i]));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            chk($sformatf("%s_idle_L%0d", nm, 16 / LAT[i]), 128'(ov[i]), 128'd0);
    endtask

    typedef struct {
        string        name;
        logic [127:0] din;
        logic         inv;
        logic [127:0] exp;
    } vec_t;

    initial begin
        vec_t         vt [5];
        int           lat;
        logic [127:0] held, d, e;
        logic         inv;

        vt[0] = '{"fips_fwd", 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 128'hd42711aee0bf98f1b8b45de51e415230};
        vt[1] = '{"fips_inv", 128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 128'h193de3bea0f4e22b9ac68d2ae9f84808};
        vt[2] = '{"zero_fwd", 128'h0, 1'b0, {16{8'h63}}};
        vt[3] = '{"b53_fwd", {16{8'h53}}, 1'b0, {16{8'hed}}};
        vt[4] = '{"b63_inv", {16{8'h63}}, 1'b1, 128'h0};

        rst = 1'b0; in_valid = 1'b0; in_inv = 1'b0; out_ready = 1'b0; state_in = '0;
        build_ref();

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 128'(ir[M]), 128'd1);
        chk("rst_out_valid", 128'(ov[M]), 128'd0);
        chk("rst_busy", 128'(bz[M]), 128'd0);
        chk("rst_state_out", so[M], 128'h0);
        rst = 1'b1;
        #1;
        chk("post_rst_in_ready", 128'(ir[M]), 128'd1);
        chk("post_rst_busy", 128'(bz[M]), 128'd0);

        for (int i = 0; i < 5; i++) run_block(vt[i].name, vt[i].din, vt[i].inv, vt[i].exp, i % 3);

        // Consumer stalls in DONE, then a back-to-back accept on the release cycle.
        d = 128'h00112233445566778899aabbccddeeff;
        @(negedge clk);
        state_in = d; in_inv = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_ov(lat);
        chk("hold_latency", 128'(lat), 128'd4);
        chk("hold_data", so[M], model(d, 1'b0, 1));
        held = so[M];
        for (int s = 0; s < 10; s++) begin
            @(posedge clk); #1;
            chk("hold_stable", so[M], held);
            chk("hold_in_ready", 128'(ir[M]), 128'd0);
        end
        d = 128'hffeeddccbbaa99887766554433221100;
        state_in = d; in_inv = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", 128'(ir[M]), 128'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_busy", 128'(bz[M]), 128'd1);
        chk("b2b_out_valid_low", 128'(ov[M]), 128'd0);
        wait_ov(lat);
        chk("b2b_latency", 128'(lat), 128'd4);
        chk("b2b_data", so[M], model(d, 1'b1, 1));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset dropped mid-RUN at cnt=2 abandons the block.
        @(negedge clk);
        state_in = 128'h0123456789abcdef0123456789abcdef; in_inv = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_busy_before", 128'(bz[M]), 128'd1);
        rst = 1'b0;
        #1;
        chk("abort_out_valid", 128'(ov[M]), 128'd0);
        chk("abort_in_ready", 128'(ir[M]), 128'd1);
        chk("abort_busy", 128'(bz[M]), 128'd0);
        chk("abort_state_out", so[M], 128'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk("abort_no_output", 128'(ov[M]), 128'd0);
        end
        run_block("after_abort", vt[0].din, 1'b0, vt[0].exp, 0);

        for (int t = 0; t < 30; t++) begin
            d   = {$urandom, $urandom, $urandom, $urandom};
            inv = 1'($urandom_range(0, 1));
            e   = model(d, inv, 1);
            run_block($sformatf("rand%0d", t), d, inv, e, int'($urandom_range(0, 3)));
        end

        // Lane-count variants, starting from a clean reset.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("multi_rst_ready_%0d", i), 128'(ir[i]), 128'd1);
            chk($sformatf("multi_rst_so_%0d", i), so[i], 128'h0);
        end
        multi_block("zero_fwd", 128'h0, 1'b0);
        multi_block("b53_inv_req", {16{8'h53}}, 1'b1);
        multi_block("fips_inv_req", vt[1].din, 1'b1);
        for (int t = 0; t < 4; t++)
            multi_block($sformatf("mrand%0d", t), {$urandom, $urandom, $urandom, $urandom},
                        1'($urandom_range(0, 1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
